// File: rtl/data_memory_responder.sv
// Data memory bus slave: latches a read/write request, inserts WAIT_STATES
// wait cycles, then performs the word access and pulses o_ready for one cycle.
module data_memory_responder #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           MEM_WORDS   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_STATES = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_rdEnable,
  input  logic                  i_wrEnable,
  input  logic [3:0]            i_byteEnable,
  input  logic [DATA_WIDTH-1:0] i_wrData,
  output logic [DATA_WIDTH-1:0] o_rdData,
  output logic                  o_ready,
  output logic                  o_error,
  output logic                  o_busy
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W = 4;
  localparam int unsigned LANES = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Range bounds carry one extra bit so BASE_ADDR + 4*MEM_WORDS cannot wrap.
  localparam logic [ADDR_WIDTH:0] RANGE_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] RANGE_HI = RANGE_LO + (ADDR_WIDTH+1)'(4 * MEM_WORDS);

  logic [DATA_WIDTH-1:0] ram [MEM_WORDS];

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  ready_q, ready_d;
  logic                  error_q, error_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [ADDR_WIDTH-1:0] acc_addr_c;
  logic                  acc_rd_c;
  logic                  acc_wr_c;
  logic [3:0]            acc_be_c;
  logic [DATA_WIDTH-1:0] acc_wdata_c;
  logic [ADDR_WIDTH-1:0] acc_off_c;
  logic [IDX_W-1:0]      acc_idx_c;
  logic                  acc_in_range_c;
  logic                  acc_err_c;
  logic                  enter_done_c;
  logic                  ram_we_c;

  // With zero wait states the access happens on the accepting edge, so the
  // operands come straight from the bus; otherwise from the latched copy.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_addr_c  = i_addr;
      acc_rd_c    = i_rdEnable;
      acc_wr_c    = i_wrEnable;
      acc_be_c    = i_byteEnable;
      acc_wdata_c = i_wrData;
    end else begin
      acc_addr_c  = addr_q;
      acc_rd_c    = rd_q;
      acc_wr_c    = wr_q;
      acc_be_c    = be_q;
      acc_wdata_c = wdata_q;
    end
    acc_off_c      = acc_addr_c - BASE_ADDR;
    acc_idx_c      = IDX_W'(acc_off_c >> 2);
    acc_in_range_c = ({1'b0, acc_addr_c} >= RANGE_LO) && ({1'b0, acc_addr_c} < RANGE_HI);
    acc_err_c      = !acc_in_range_c || (acc_rd_c && acc_wr_c);
  end

  // Next-state, request latch and completion outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    ready_d      = 1'b0;
    error_d      = 1'b0;
    rdata_d      = rdata_q;
    ram_we_c     = 1'b0;
    enter_done_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_rdEnable || i_wrEnable) begin
          addr_d  = i_addr;
          rd_d    = i_rdEnable;
          wr_d    = i_wrEnable;
          be_d    = i_byteEnable;
          wdata_d = i_wrData;
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    enter_done_c = (state_d == ST_DONE) && (state_q != ST_DONE);
    if (enter_done_c) begin
      ready_d = 1'b1;
      if (acc_err_c) begin
        error_d = 1'b1;
      end else if (acc_rd_c) begin
        rdata_d = ram[acc_idx_c];
      end else begin
        ram_we_c = !i_reset;
      end
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      error_q <= error_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM is not reset; byte lanes are written independently.
  always_ff @(posedge i_clock) begin
    if (ram_we_c) begin
      for (int b = 0; b < LANES; b++) begin
        if (acc_be_c[b]) begin
          ram[acc_idx_c][8*b +: 8] <= acc_wdata_c[8*b +: 8];
        end
      end
    end
  end

  assign o_rdData = rdata_q;
  assign o_ready  = ready_q;
  assign o_error  = error_q;
  assign o_busy   = busy_q;

endmodule
